pipelined_ctrl_unit: RTL

Registered, hazard-aware control stage of the RV32I pipeline: sits between the IF/ID register and the EX stage. It decodes the instruction held in IF/ID into control signals and latches them, with register indices and funct3, into the ID/EX control register. It also:
- detects load-use hazards and stalls the front end;
- inserts bubbles on flush, illegal opcode, or halt;
- optionally halts the core on ECALL/EBREAK.

---
 rtl/pipelined_ctrl_unit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_ctrl_unit.sv
// ID-stage control decode with an ID/EX control register, load-use stall,
// bubble insertion on flush/illegal/halt, and a sticky ECALL/EBREAK halt.
module pipelined_ctrl_unit #(
  parameter int unsigned NB_INSTR    = 32,
  parameter int unsigned NB_REG_ADDR = 5,
  parameter bit          SYSTEM_HALT = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NB_INSTR-1:0]    i_instr,
  input  logic                   i_instr_valid,
  input  logic                   i_flush,
  input  logic                   i_hold,
  output logic                   o_stall,
  output logic                   o_valid,
  output logic                   o_RegWrite,
  output logic                   o_MemRead,
  output logic                   o_MemWrite,
  output logic                   o_ALUSrc,
  output logic                   o_MemToReg,
  output logic                   o_Branch,
  output logic                   o_Jump,
  output logic [1:0]             o_ALUOp,
  output logic [NB_REG_ADDR-1:0] o_rd,
  output logic [NB_REG_ADDR-1:0] o_rs1,
  output logic [NB_REG_ADDR-1:0] o_rs2,
  output logic [2:0]             o_funct3,
  output logic                   o_illegal,
  output logic                   o_halted
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  typedef struct packed {
    logic                   valid;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   alu_src;
    logic                   mem_to_reg;
    logic                   branch;
    logic                   jump;
    logic [1:0]             alu_op;
    logic [NB_REG_ADDR-1:0] rd;
    logic [NB_REG_ADDR-1:0] rs1;
    logic [NB_REG_ADDR-1:0] rs2;
    logic [2:0]             funct3;
  } idex_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic       unused_instr_bits;

  assign opcode            = i_instr[6:0];
  assign rd_f              = i_instr[11:7];
  assign funct3            = i_instr[14:12];
  assign rs1_f             = i_instr[19:15];
  assign rs2_f             = i_instr[24:20];
  assign unused_instr_bits = ^i_instr[NB_INSTR-1:25];

  idex_t  dec;
  logic   legal;
  logic   halt_instr;
  logic   use_rs1;
  logic   use_rs2;

  always_comb begin
    dec            = '0;
    dec.valid      = 1'b1;
    dec.rd         = NB_REG_ADDR'(rd_f);
    dec.rs1        = NB_REG_ADDR'(rs1_f);
    dec.rs2        = NB_REG_ADDR'(rs2_f);
    dec.funct3     = funct3;
    legal          = 1'b1;
    halt_instr     = 1'b0;
    use_rs1        = 1'b0;
    use_rs2        = 1'b0;
    unique case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_I_ALU: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b10;
        use_rs1       = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        use_rs1        = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.jump      = 1'b1;
        use_rs1       = 1'b1;
      end
      OP_SYSTEM: begin
        if (funct3 != 3'b000) begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          use_rs1       = 1'b1;
        end else if (SYSTEM_HALT) begin
          halt_instr = 1'b1;
        end
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = 2'b01;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Writes to x0 are architecturally discarded; suppress them here.
    if (rd_f == 5'd0) dec.reg_write = 1'b0;
  end

  idex_t  idex_q, idex_d;
  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   haz;

  always_comb begin
    haz = idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) && i_instr_valid &&
          ((use_rs1 && (idex_q.rd == dec.rs1)) || (use_rs2 && (idex_q.rd == dec.rs2)));
  end

  always_comb begin
    o_stall = 1'b0;
    if (i_hold)                      o_stall = 1'b1;
    else if (state_q == ST_HALTED)   o_stall = 1'b1;
    else if (i_flush)                o_stall = 1'b0;
    else if (haz)                    o_stall = 1'b1;
  end

  always_comb begin
    idex_d    = idex_q;
    state_d   = state_q;
    illegal_d = illegal_q;
    if (i_hold) begin
      idex_d = idex_q;
    end else if (state_q == ST_HALTED) begin
      idex_d = '0;
    end else if (i_flush || haz) begin
      idex_d = '0;
    end else if (!i_instr_valid || !legal) begin
      idex_d = '0;
      if (i_instr_valid) illegal_d = 1'b1;
    end else if (halt_instr) begin
      idex_d  = '0;
      state_d = ST_HALTED;
    end else begin
      idex_d = dec;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idex_q    <= '0;
      state_q   <= ST_RUN;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_valid    = idex_q.valid;
  assign o_RegWrite = idex_q.reg_write;
  assign o_MemRead  = idex_q.mem_read;
  assign o_MemWrite = idex_q.mem_write;
  assign o_ALUSrc   = idex_q.alu_src;
  assign o_MemToReg = idex_q.mem_to_reg;
  assign o_Branch   = idex_q.branch;
  assign o_Jump     = idex_q.jump;
  assign o_ALUOp    = idex_q.alu_op;
  assign o_rd       = idex_q.rd;
  assign o_rs1      = idex_q.rs1;
  assign o_rs2      = idex_q.rs2;
  assign o_funct3   = idex_q.funct3;
  assign o_illegal  = illegal_q;
  assign o_halted   = (state_q == ST_HALTED);

endmodule
